// File: rtl/irrigation_pkg.sv
// Shared types and tank-probe helpers for the multi-zone irrigation scheduler.
package irrigation_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        GAP   = 2'd3
    } state_e;

    typedef enum logic {
        MODE_DRIP  = 1'b0,
        MODE_SPRAY = 1'b1
    } mode_e;

    // A wetter probe above a dry one is physically impossible: flag it.
    function automatic logic tank_erro(input logic alta, input logic media, input logic baixa);
        return (alta & ~media) | (alta & ~baixa) | (media & ~baixa);
    endfunction

    function automatic mode_e pick_mode(input logic umid, input logic temp);
        return (!umid && !temp) ? MODE_SPRAY : MODE_DRIP;
    endfunction

endpackage

// File: rtl/irrigation_scheduler_if.sv
// Sensor inputs and actuator/status outputs of the irrigation scheduler.
interface irrigation_scheduler_if #(
    parameter int ZONES = 4,
    parameter int CNT_W = 8
);
    localparam int IDX_W = $clog2(ZONES);

    logic               alta;
    logic               media;
    logic               baixa;
    logic [ZONES-1:0]   solo;
    logic [ZONES-1:0]   umidade;
    logic [ZONES-1:0]   temperatura;
    logic               erro;
    logic               alarme;
    logic               ve;
    logic [ZONES-1:0]   valve;
    logic               gotejamento;
    logic               aspersao;
    logic [IDX_W-1:0]   zone_idx;
    logic [CNT_W-1:0]   remaining;
    logic               busy;

    modport master (
        output alta, media, baixa, solo, umidade, temperatura,
        input  erro, alarme, ve, valve, gotejamento, aspersao, zone_idx, remaining, busy
    );

    modport slave (
        input  alta, media, baixa, solo, umidade, temperatura,
        output erro, alarme, ve, valve, gotejamento, aspersao, zone_idx, remaining, busy
    );

endinterface

// File: rtl/irrigation_scheduler_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_q;
    logic          tick_d;
    logic          wrap_s;

    assign wrap_s = (cnt_q == CW'(TICK_DIV - 1));

    // Prescaler next state.
    always_comb begin
        cnt_d  = cnt_q + CW'(1);
        tick_d = 1'b0;
        if (wrap_s) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            tick_d = 1'b0;
        end
    end

    // Prescaler and tick registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/irrigation_scheduler.sv
// Round-robin multi-zone irrigation scheduler with tank supervision.
// Define IRRIGATION_SYNC_EN to pass all sensor inputs through two-flop synchronisers.
module irrigation_scheduler
    import irrigation_pkg::*;
#(
    parameter int ZONES      = 4,
    parameter int TICK_DIV   = 50_000_000,
    parameter int CNT_W      = 8,
    parameter int DRIP_TIME  = 8,
    parameter int SPRAY_TIME = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    irrigation_scheduler_if.slave  bus
);

    localparam int IDX_W = $clog2(ZONES);
    localparam int SW    = 3 + 3 * ZONES;

    logic             alta_s;
    logic             media_s;
    logic             baixa_s;
    logic [ZONES-1:0] solo_s;
    logic [ZONES-1:0] umid_s;
    logic [ZONES-1:0] temp_s;
    logic [SW-1:0]    raw_s;

    assign raw_s = {bus.alta, bus.media, bus.baixa, bus.solo, bus.umidade, bus.temperatura};

`ifdef IRRIGATION_SYNC_EN
    logic [SW-1:0] sync1_q;
    logic [SW-1:0] sync2_q;

    // Two-flop synchroniser for every sensor line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_s;
            sync2_q <= sync1_q;
        end
    end

    assign {alta_s, media_s, baixa_s, solo_s, umid_s, temp_s} = sync2_q;
`else
    assign {alta_s, media_s, baixa_s, solo_s, umid_s, temp_s} = raw_s;
`endif

    logic erro_s;
    logic alarme_s;
    logic tick_s;

    assign erro_s     = tank_erro(alta_s, media_s, baixa_s);
    assign alarme_s   = erro_s | ~baixa_s;
    assign bus.erro   = erro_s;
    assign bus.alarme = alarme_s;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .tick_o (tick_s)
    );

    logic ve_q;
    logic ve_d;

    // Fill valve hysteresis: a full or faulty tank always wins over refill.
    always_comb begin
        ve_d = ve_q;
        if (alta_s || erro_s) begin
            ve_d = 1'b0;
        end else if (!media_s) begin
            ve_d = 1'b1;
        end else begin
            ve_d = ve_q;
        end
    end

    // Fill valve register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ve_q <= 1'b0;
        end else begin
            ve_q <= ve_d;
        end
    end

    state_e           state_q;
    state_e           state_d;
    mode_e            mode_q;
    mode_e            mode_d;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] ptr_next_s;
    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] rem_d;
    logic [ZONES-1:0] valve_q;
    logic [ZONES-1:0] valve_d;
    logic             drip_q;
    logic             drip_d;
    logic             spray_q;
    logic             spray_d;
    logic             busy_q;
    logic             busy_d;

    assign ptr_next_s = (ptr_q == IDX_W'(ZONES - 1)) ? '0 : ptr_q + IDX_W'(1);

    // State, pointer, run counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= MODE_DRIP;
            ptr_q   <= '0;
            rem_q   <= '0;
            valve_q <= '0;
            drip_q  <= 1'b0;
            spray_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            valve_q <= valve_d;
            drip_q  <= drip_d;
            spray_q <= spray_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic; an alarm in RUN outranks the early stop.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (!solo_s[ptr_q] && !alarme_s) begin
                    state_d = RUN;
                    mode_d  = pick_mode(umid_s[ptr_q], temp_s[ptr_q]);
                    rem_d   = (mode_d == MODE_SPRAY) ? CNT_W'(SPRAY_TIME) : CNT_W'(DRIP_TIME);
                end else begin
                    ptr_d = ptr_next_s;
                end
            end
            RUN: begin
                if (alarme_s) begin
                    state_d = PAUSE;
                end else if (solo_s[ptr_q]) begin
                    state_d = GAP;
                    rem_d   = '0;
                end else if (tick_s) begin
                    if (rem_q == CNT_W'(1)) begin
                        state_d = GAP;
                        rem_d   = '0;
                    end else begin
                        rem_d = rem_q - CNT_W'(1);
                    end
                end else begin
                    rem_d = rem_q;
                end
            end
            PAUSE: begin
                if (!alarme_s) begin
                    state_d = RUN;
                end else begin
                    state_d = PAUSE;
                end
            end
            GAP: begin
                rem_d = '0;
                if (tick_s) begin
                    state_d = IDLE;
                    ptr_d   = ptr_next_s;
                end else begin
                    state_d = GAP;
                end
            end
            default: begin
                state_d = IDLE;
                rem_d   = '0;
            end
        endcase
    end

    // Output decode from the next state so outputs land with the state change.
    always_comb begin
        valve_d = '0;
        drip_d  = 1'b0;
        spray_d = 1'b0;
        busy_d  = 1'b0;
        case (state_d)
            RUN: begin
                valve_d = ZONES'(1) << ptr_d;
                drip_d  = (mode_d == MODE_DRIP);
                spray_d = (mode_d == MODE_SPRAY);
                busy_d  = 1'b1;
            end
            PAUSE:   busy_d = 1'b1;
            GAP:     busy_d = 1'b1;
            IDLE:    busy_d = 1'b0;
            default: busy_d = 1'b0;
        endcase
    end

    assign bus.ve          = ve_q;
    assign bus.valve       = valve_q;
    assign bus.gotejamento = drip_q;
    assign bus.aspersao    = spray_q;
    assign bus.busy        = busy_q;
    assign bus.zone_idx    = ptr_q;
    assign bus.remaining   = rem_q;

endmodule
